// File: rtl/res_sel_pkg.sv
// Shared definitions for the result-select pipeline: flag bit positions,
// FSM state encoding and the select-width helper.
package res_sel_pkg;

    localparam int unsigned FLAG_W = 4;
    localparam int unsigned N_BIT  = 3;
    localparam int unsigned Z_BIT  = 2;
    localparam int unsigned V_BIT  = 1;
    localparam int unsigned C_BIT  = 0;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        BUSY  = 2'd1,
        FULL  = 2'd2
    } state_e;

    // Width of the channel index: clog2(NUM_CH), but never below one bit.
    function automatic int unsigned sel_width(input int unsigned num_ch);
        return (num_ch <= 2) ? 1 : $clog2(num_ch);
    endfunction

endpackage

// File: rtl/result_select_pipe_if.sv
// Handshake and data bus of the result-select pipeline.
// slave: the pipeline's view; master: the upstream/downstream driver's view.
interface result_select_pipe_if #(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 8
);
    import res_sel_pkg::*;

    localparam int unsigned SEL_W = sel_width(NUM_CH);

    logic                       in_valid;
    logic                       in_ready;
    logic [SEL_W-1:0]           sel;
    logic [NUM_CH*DATA_W-1:0]   in_data;
    logic [NUM_CH*FLAG_W-1:0]   in_flags;
    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_W-1:0]          out_data;
    logic [FLAG_W-1:0]          out_flags;
    logic [SEL_W-1:0]           out_ch;
    logic                       sel_err;

    modport slave (
        input  in_valid, sel, in_data, in_flags, out_ready,
        output in_ready, out_valid, out_data, out_flags, out_ch, sel_err
    );

    modport master (
        output in_valid, sel, in_data, in_flags, out_ready,
        input  in_ready, out_valid, out_data, out_flags, out_ch, sel_err
    );

endinterface

// File: rtl/res_sel_mux.sv
// Combinational NUM_CH-way selection of result data and NZVC flags.
// An out-of-range index yields zero data/flags and raises err.
module res_sel_mux
    import res_sel_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 8,
    parameter int unsigned SEL_W  = 1
) (
    input  logic [SEL_W-1:0]         sel,
    input  logic [NUM_CH*DATA_W-1:0] in_data,
    input  logic [NUM_CH*FLAG_W-1:0] in_flags,
    output logic [DATA_W-1:0]        data,
    output logic [FLAG_W-1:0]        flags,
    output logic                     err
);

    logic [31:0] sel_idx;

    // Pick the channel addressed by sel; default zero when nothing matches.
    always_comb begin
        sel_idx = 32'(sel);
        data    = '0;
        flags   = '0;
        err     = (sel_idx >= NUM_CH);
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (sel_idx == k) begin
                data  = in_data[k*DATA_W +: DATA_W];
                flags = in_flags[k*FLAG_W +: FLAG_W];
            end
        end
    end

endmodule

// File: rtl/result_select_pipe.sv
// Result-select pipeline: picks one channel's result and flags per accepted
// beat, buffers it in a two-entry skid buffer, and tracks an NZVC status
// register updated on every output transfer.
// Optional feature: define RES_SEL_STICKY_EN to make status V/C sticky
// (cleared by sticky_clr).
module result_select_pipe
    import res_sel_pkg::*;
#(
    parameter int unsigned NUM_CH = 2,
    parameter int unsigned DATA_W = 8
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                sticky_clr,
    output logic [FLAG_W-1:0]   status_nzvc,
    result_select_pipe_if.slave bus
);

    localparam int unsigned SEL_W = sel_width(NUM_CH);

    logic [DATA_W-1:0] mux_data;
    logic [FLAG_W-1:0] mux_flags;
    logic              mux_err;

    res_sel_mux #(
        .NUM_CH (NUM_CH),
        .DATA_W (DATA_W),
        .SEL_W  (SEL_W)
    ) u_mux (
        .sel      (bus.sel),
        .in_data  (bus.in_data),
        .in_flags (bus.in_flags),
        .data     (mux_data),
        .flags    (mux_flags),
        .err      (mux_err)
    );

    state_e            state_q,      state_d;
    logic              in_ready_q,   in_ready_d;
    logic              out_valid_q,  out_valid_d;
    logic [DATA_W-1:0] main_data_q,  main_data_d;
    logic [FLAG_W-1:0] main_flags_q, main_flags_d;
    logic [SEL_W-1:0]  main_ch_q,    main_ch_d;
    logic              main_err_q,   main_err_d;
    logic [DATA_W-1:0] skid_data_q,  skid_data_d;
    logic [FLAG_W-1:0] skid_flags_q, skid_flags_d;
    logic [SEL_W-1:0]  skid_ch_q,    skid_ch_d;
    logic              skid_err_q,   skid_err_d;
    logic [FLAG_W-1:0] status_q,     status_d;

    logic accept;
    logic xfer;

    assign accept = bus.in_valid && in_ready_q;
    assign xfer   = out_valid_q && bus.out_ready;

    // Skid-buffer next state: main drives the outputs, skid absorbs the one
    // beat accepted while the output is stalled.
    always_comb begin
        state_d      = state_q;
        main_data_d  = main_data_q;
        main_flags_d = main_flags_q;
        main_ch_d    = main_ch_q;
        main_err_d   = main_err_q;
        skid_data_d  = skid_data_q;
        skid_flags_d = skid_flags_q;
        skid_ch_d    = skid_ch_q;
        skid_err_d   = skid_err_q;
        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_data_d  = mux_data;
                    main_flags_d = mux_flags;
                    main_ch_d    = bus.sel;
                    main_err_d   = mux_err;
                    state_d      = BUSY;
                end
            end
            BUSY: begin
                if (accept && xfer) begin
                    main_data_d  = mux_data;
                    main_flags_d = mux_flags;
                    main_ch_d    = bus.sel;
                    main_err_d   = mux_err;
                end else if (accept) begin
                    skid_data_d  = mux_data;
                    skid_flags_d = mux_flags;
                    skid_ch_d    = bus.sel;
                    skid_err_d   = mux_err;
                    state_d      = FULL;
                end else if (xfer) begin
                    state_d      = EMPTY;
                end
            end
            FULL: begin
                if (xfer) begin
                    main_data_d  = skid_data_q;
                    main_flags_d = skid_flags_q;
                    main_ch_d    = skid_ch_q;
                    main_err_d   = skid_err_q;
                    state_d      = BUSY;
                end
            end
            default: state_d = EMPTY;
        endcase
        in_ready_d  = (state_d != FULL);
        out_valid_d = (state_d != EMPTY);
    end

    // Status register: loads the transferred flags; V/C optionally sticky.
    always_comb begin
        status_d = status_q;
        if (xfer) begin
            status_d = main_flags_q;
        end
`ifdef RES_SEL_STICKY_EN
        if (xfer && !sticky_clr) begin
            status_d[V_BIT] = status_q[V_BIT] | main_flags_q[V_BIT];
            status_d[C_BIT] = status_q[C_BIT] | main_flags_q[C_BIT];
        end else if (!xfer && sticky_clr) begin
            status_d[V_BIT] = 1'b0;
            status_d[C_BIT] = 1'b0;
        end
`endif
    end

`ifndef RES_SEL_STICKY_EN
    logic unused_sticky_clr;
    assign unused_sticky_clr = sticky_clr;
`endif

    // FSM and all registered state, asynchronously cleared.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= EMPTY;
            in_ready_q   <= 1'b1;
            out_valid_q  <= 1'b0;
            main_data_q  <= '0;
            main_flags_q <= '0;
            main_ch_q    <= '0;
            main_err_q   <= 1'b0;
            skid_data_q  <= '0;
            skid_flags_q <= '0;
            skid_ch_q    <= '0;
            skid_err_q   <= 1'b0;
            status_q     <= '0;
        end else begin
            state_q      <= state_d;
            in_ready_q   <= in_ready_d;
            out_valid_q  <= out_valid_d;
            main_data_q  <= main_data_d;
            main_flags_q <= main_flags_d;
            main_ch_q    <= main_ch_d;
            main_err_q   <= main_err_d;
            skid_data_q  <= skid_data_d;
            skid_flags_q <= skid_flags_d;
            skid_ch_q    <= skid_ch_d;
            skid_err_q   <= skid_err_d;
            status_q     <= status_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid_q;
    assign bus.out_data  = main_data_q;
    assign bus.out_flags = main_flags_q;
    assign bus.out_ch    = main_ch_q;
    assign bus.sel_err   = main_err_q;
    assign status_nzvc   = status_q;

endmodule

// File: tb/tb_result_select_pipe.sv
// Directed bench for result_select_pipe (NUM_CH=3, DATA_W=8).
module tb_result_select_pipe;

    localparam int unsigned NUM_CH = 3;
    localparam int unsigned DATA_W = 8;

    logic       clk;
    logic       rst_n;
    logic       sticky_clr;
    logic [3:0] status_nzvc;

    int n_total;
    int n_bad;

    result_select_pipe_if #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) bus ();

    result_select_pipe #(.NUM_CH(NUM_CH), .DATA_W(DATA_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sticky_clr  (sticky_clr),
        .status_nzvc (status_nzvc),
        .bus         (bus)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Advance past the next rising edge and settle.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        n_total       = 0;
        n_bad         = 0;
        rst_n         = 1'b0;
        sticky_clr    = 1'b0;
        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.sel       = 2'd0;
        bus.in_data   = {8'h33, 8'h55, 8'hAA};
        bus.in_flags  = {4'b0101, 4'b0011, 4'b1100};
        #2;
        check_val("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check_val("rst_out_data",  64'(bus.out_data),  64'd0);
        check_val("rst_out_flags", 64'(bus.out_flags), 64'd0);
        check_val("rst_out_ch",    64'(bus.out_ch),    64'd0);
        check_val("rst_sel_err",   64'(bus.sel_err),   64'd0);
        check_val("rst_status",    64'(status_nzvc),   64'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("rst_in_ready", 64'(bus.in_ready), 64'd1);

        // sel=0 then sel=1, one-cycle latency
        bus.in_valid = 1'b1; bus.sel = 2'd0;
        tick();
        check_val("s0_valid", 64'(bus.out_valid), 64'd1);
        check_val("s0_data",  64'(bus.out_data),  64'hAA);
        check_val("s0_flags", 64'(bus.out_flags), 64'hC);
        check_val("s0_ch",    64'(bus.out_ch),    64'd0);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        check_val("s0_drain",  64'(bus.out_valid), 64'd0);
        check_val("s0_status", 64'(status_nzvc),   64'hC);
        bus.in_valid = 1'b1; bus.sel = 2'd1; bus.out_ready = 1'b0;
        tick();
        check_val("s1_data",  64'(bus.out_data),  64'h55);
        check_val("s1_flags", 64'(bus.out_flags), 64'h3);
        check_val("s1_ch",    64'(bus.out_ch),    64'd1);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        tick();
        check_val("s1_status", 64'(status_nzvc), 64'h3);

        // Backpressure: three beats offered while stalled
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.sel = 2'd0;
        bus.in_data = {8'h33, 8'h55, 8'h01};
        tick();
        check_val("bp_ready1", 64'(bus.in_ready), 64'd1);
        bus.in_data = {8'h33, 8'h55, 8'h02};
        tick();
        check_val("bp_ready2", 64'(bus.in_ready), 64'd0);
        check_val("bp_hold2",  64'(bus.out_data), 64'h01);
        bus.in_data = {8'h33, 8'h55, 8'h03};
        tick();
        tick();
        check_val("bp_hold4",  64'(bus.out_data), 64'h01);
        check_val("bp_ready4", 64'(bus.in_ready), 64'd0);
        bus.out_ready = 1'b1;
        tick();
        check_val("bp_out2",   64'(bus.out_data), 64'h02);
        check_val("bp_ready5", 64'(bus.in_ready), 64'd1);
        tick();
        check_val("bp_out3", 64'(bus.out_data),  64'h03);
        check_val("bp_v3",   64'(bus.out_valid), 64'd1);
        bus.in_valid = 1'b0;
        tick();
        check_val("bp_empty", 64'(bus.out_valid), 64'd0);

        // Out-of-range select, then a valid beat
        bus.in_data = {8'h33, 8'h55, 8'hAA};
        bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.sel = 2'd3;
        tick();
        check_val("err_data",  64'(bus.out_data),  64'd0);
        check_val("err_flags", 64'(bus.out_flags), 64'd0);
        check_val("err_flag",  64'(bus.sel_err),   64'd1);
        check_val("err_ch",    64'(bus.out_ch),    64'd3);
        bus.out_ready = 1'b1; bus.sel = 2'd2;
        tick();
        check_val("ok_data",  64'(bus.out_data),  64'h33);
        check_val("ok_flags", 64'(bus.out_flags), 64'h5);
        check_val("ok_err",   64'(bus.sel_err),   64'd0);
        check_val("ok_ch",    64'(bus.out_ch),    64'd2);

        // Streaming: one beat per cycle, in_ready stays high
        bus.sel = 2'd0;
        for (int i = 0; i < 5; i++) begin
            bus.in_data = {8'h33, 8'h55, 8'(8'h10 + i)};
            tick();
            check_val("st_data",  64'(bus.out_data), 64'(8'h10 + i));
            check_val("st_ready", 64'(bus.in_ready), 64'd1);
        end
        bus.in_valid = 1'b0;
        tick();
        check_val("st_status", 64'(status_nzvc), 64'hC);

        // Sticky V/C behaviour
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        check_val("sk_clr0", 64'(status_nzvc), 64'hC);
        bus.in_flags = {4'b0101, 4'b0011, 4'b0010};
        bus.in_valid = 1'b1;
        tick();
        bus.in_flags = {4'b0101, 4'b0011, 4'b0000};
        tick();
        check_val("sk_first", 64'(status_nzvc), 64'h2);
        bus.in_valid = 1'b0;
        tick();
`ifdef RES_SEL_STICKY_EN
        check_val("sk_second", 64'(status_nzvc), 64'h2);
`else
        check_val("sk_second", 64'(status_nzvc), 64'h0);
`endif
        sticky_clr = 1'b1;
        tick();
        sticky_clr = 1'b0;
        check_val("sk_clr1", 64'(status_nzvc), 64'h0);

        // Reset while FULL
        bus.in_flags = {4'b0101, 4'b0011, 4'b1100};
        bus.in_valid = 1'b1; bus.out_ready = 1'b1;
        tick();
        tick();
        bus.out_ready = 1'b0;
        tick();
        check_val("fr_full",   64'(bus.in_ready), 64'd0);
        check_val("fr_status", 64'(status_nzvc),  64'hC);
        #2;
        rst_n = 1'b0;
        #1;
        check_val("fr_valid0",  64'(bus.out_valid), 64'd0);
        check_val("fr_status0", 64'(status_nzvc),   64'd0);
        check_val("fr_data0",   64'(bus.out_data),  64'd0);
        bus.in_valid = 1'b0; bus.out_ready = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check_val("fr_ready", 64'(bus.in_ready),  64'd1);
        check_val("fr_valid", 64'(bus.out_valid), 64'd0);
        tick();
        check_val("fr_valid2", 64'(bus.out_valid), 64'd0);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/result_select_pipe.md
RESULT_SELECT_PIPE -- requirements
Module: result_select_pipe

Interface
REQ-001 Parameter NUM_CH, default 2: number of result channels, legal range 2..16.
REQ-002 Parameter DATA_W, default 8: result width in bits, legal range 4..64.
REQ-003 Derived constant SEL_W = max(1, clog2(NUM_CH)); flag width fixed at 4 bits, ordered {N,Z,V,C}.
REQ-004 Port clk  input  1  single clock; all state updates on its rising edge.
REQ-005 Port rst_n  input  1  asynchronous, active-low reset.
REQ-006 Port in_valid  input  1  upstream beat present.
REQ-007 Port in_ready  output  1  block can accept a beat; driven from a register.
REQ-008 Port sel  input  SEL_W  channel index, sampled with the beat.
REQ-009 Port in_data  input  NUM_CH*DATA_W  channel k result in bits [k*DATA_W +: DATA_W].
REQ-010 Port in_flags  input  NUM_CH*4  channel k NZVC in bits [k*4 +: 4].
REQ-011 Port out_valid  output  1  output beat present.
REQ-012 Port out_ready  input  1  downstream accepts the beat.
REQ-013 Port out_data  output  DATA_W  selected result.
REQ-014 Port out_flags  output  4  selected NZVC.
REQ-015 Port out_ch  output  SEL_W  channel index of the output beat.
REQ-016 Port sel_err  output  1  output beat came from an out-of-range sel.
REQ-017 Port status_nzvc  output  4  architectural status register.
REQ-018 Port sticky_clr  input  1  clears the sticky V/C bits; used only with RES_SEL_STICKY_EN.

Function
REQ-019 Input handshake: a beat is accepted when in_valid && in_ready.
REQ-020 Output handshake: a beat is transferred when out_valid && out_ready.
REQ-021 The accepted beat captures in_data/in_flags of channel sel, together with sel.
REQ-022 If sel >= NUM_CH, the captured data and flags are 0 and sel_err is 1 for that beat.
REQ-023 Latency is one cycle: a beat accepted in an EMPTY cycle is presented on out_* in the next cycle.
REQ-024 Storage is a two-entry skid buffer: main register drives out_*; a skid register holds the overflow beat.
REQ-025 FSM EMPTY: accept -> BUSY.
REQ-026 FSM BUSY: accept with transfer -> BUSY, main reloaded; accept without transfer -> FULL, skid loaded; transfer without accept -> EMPTY.
REQ-027 FSM FULL: transfer -> BUSY, skid moved to main; no transfer -> FULL.
REQ-028 in_ready = (state != FULL), registered; out_valid = (state != EMPTY).
REQ-029 While out_valid && !out_ready, out_data, out_flags, out_ch and sel_err are held stable.
REQ-030 Order is preserved; no beat is dropped or duplicated.
REQ-031 status_nzvc loads out_flags on every output transfer; otherwise it holds.

Reset
REQ-032 Asserting rst_n low immediately sets: state EMPTY, out_valid 0, in_ready 1 after release, out_data 0, out_flags 0, out_ch 0, sel_err 0, status_nzvc 0, sticky bits 0.
REQ-033 Any beat in flight when reset is asserted mid-operation is discarded; no output transfer occurs until a new beat is accepted.

Configuration
REQ-034 Macro RES_SEL_STICKY_EN defined: status_nzvc V and C are sticky.
- On each output transfer: V/C = old | new; N/Z load normally.
- sticky_clr forces V/C to 0.
- If sticky_clr coincides with a transfer, V/C take the new flags only.
REQ-035 Macro RES_SEL_STICKY_EN undefined: all four status bits load normally, and sticky_clr is ignored.

Structure
REQ-036 Shared package res_sel_pkg holds:
- flag bit index constants N_BIT=3, Z_BIT=2, V_BIT=1, C_BIT=0;
- the FSM state typedef {EMPTY, BUSY, FULL}.
REQ-037 One sub-module, res_sel_mux: combinational NUM_CH-way selection of data+flags with range check; instantiated once.

Verification
REQ-038 NUM_CH=2, DATA_W=8: in_data ch0=0xAA, ch1=0x55, in_flags ch0=4'b1100, ch1=4'b0011.
- sel=0 -> next cycle out_data=0xAA, out_flags=1100.
- sel=1 -> next cycle out_data=0x55, out_flags=0011.
REQ-039 Backpressure: out_ready=0 while 3 beats (0x01, 0x02, 0x03) are offered.
- in_ready drops after 2 beats are accepted.
- Release -> 0x01 then 0x02 then 0x03 in order, none lost.
REQ-040 NUM_CH=3, sel=3 -> out_data=0, out_flags=0, sel_err=1; the next valid beat has sel_err=0.
REQ-041 Continuous streaming with out_ready=1: throughput of one beat per cycle, in_ready remains 1.
REQ-042 With RES_SEL_STICKY_EN: transfer flags 0010 then 0000 -> status_nzvc=0010 (N=0, Z=0, V=1, C=0); then sticky_clr -> 0000. Without the macro the same sequence gives 0000 after the second transfer.
REQ-043 rst_n low while in state FULL -> out_valid=0 immediately, status_nzvc=0, in_ready=1 after release.
